// File: rtl/fetch_read_arbiter.sv
// Round-robin arbiter sharing one read-master fetch port among NUM_REQ requesters.
// A grant is held until every beat of the whole fetch has been handed back to the winner.
module fetch_read_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned MAX_BYTE_COUNT    = 1000000000,
    parameter int unsigned AXI_ADDRESS_WIDTH = 34,
    parameter int unsigned DATA_WIDTH        = 512,
    localparam int unsigned BCW              = $clog2(MAX_BYTE_COUNT),
    localparam int unsigned AW               = AXI_ADDRESS_WIDTH,
    localparam int unsigned IDW              = $clog2(NUM_REQ)
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*AW-1:0]    req_start_address,
    input  logic [NUM_REQ*BCW-1:0]   req_byte_count,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [NUM_REQ-1:0]       resp_last,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     fetch_req_valid,
    input  logic                     fetch_req_ready,
    output logic [AW-1:0]            fetch_start_address,
    output logic [BCW-1:0]           fetch_byte_count,
    input  logic                     fetch_resp_valid,
    output logic                     fetch_resp_ready,
    input  logic [DATA_WIDTH-1:0]    fetch_resp_data,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    localparam int unsigned BLW = BCW - 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [IDW-1:0]  grant_d;
    logic [IDW-1:0]  rr_ptr, rr_d;
    logic [BLW-1:0]  beats_left, beats_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand;
    logic [BCW-1:0]  pick_bc;
    logic [BCW-1:0]  grant_bc;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
    endfunction

    // First asserted request searching upward from rr_ptr, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_bc             = req_byte_count[pick_idx*BCW +: BCW];
    assign grant_bc            = req_byte_count[grant_id*BCW +: BCW];
    assign fetch_start_address = req_start_address[grant_id*AW +: AW];
    assign fetch_byte_count    = grant_bc;
    assign resp_data           = fetch_resp_data;
    assign busy                = (state != IDLE);

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_d;
            grant_id   <= grant_d;
            rr_ptr     <= rr_d;
            beats_left <= beats_d;
        end
    end

    // Next-state and handshake routing; only the granted lane ever sees ready/valid.
    always_comb begin
        state_d          = state;
        grant_d          = grant_id;
        rr_d             = rr_ptr;
        beats_d          = beats_left;
        req_ready        = '0;
        resp_valid       = '0;
        resp_last        = '0;
        fetch_req_valid  = 1'b0;
        fetch_resp_ready = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    if (pick_bc == '0) begin
                        req_ready[pick_idx] = 1'b1;
                        rr_d                = wrap_inc(pick_idx);
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                fetch_req_valid     = req_valid[grant_id];
                req_ready[grant_id] = fetch_req_ready;
                if (!req_valid[grant_id]) begin
                    state_d = IDLE;
                end else if (fetch_req_ready) begin
                    beats_d = BLW'(grant_bc[BCW-1:6]) + BLW'(grant_bc[5:0] != 6'd0);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                resp_valid[grant_id] = fetch_resp_valid;
                resp_last[grant_id]  = fetch_resp_valid && (beats_left == BLW'(1));
                fetch_resp_ready     = resp_ready[grant_id];
                if (fetch_resp_valid && resp_ready[grant_id]) begin
                    beats_d = beats_left - BLW'(1);
                    if (beats_left == BLW'(1)) begin
                        state_d = IDLE;
                        rr_d    = wrap_inc(grant_id);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_read_arbiter.md
# fetch_read_arbiter

Round-robin arbiter that shares one `axi_read_master` fetch port between `NUM_REQ` requesters. It grants one fetch at a time and forwards the winner's request to the read master. It then routes every response beat back to the winner and counts beats. The grant is released only after the whole fetch has drained, not at the per-burst `fetch_resp_last`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `MAX_BYTE_COUNT`, 1000000000: maximum fetch size; `BCW = $clog2(MAX_BYTE_COUNT)`.
- `AXI_ADDRESS_WIDTH`, 34: address width (`AW`).
- `DATA_WIDTH`, 512: beat width; one beat carries 64 bytes.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `core_clk` in 1: clock.
  - `rst` in 1: asynchronous, active-high reset.
- Requester request side:
  - `req_valid` in `NUM_REQ`: per-requester fetch request.
  - `req_ready` out `NUM_REQ`: per-requester request accept (one-hot or zero).
  - `req_start_address` in `NUM_REQ*AW`: packed start addresses; requester i uses slice i.
  - `req_byte_count` in `NUM_REQ*BCW`: packed byte counts.
- Requester response side:
  - `resp_valid` out `NUM_REQ`: response beat valid to the granted requester only.
  - `resp_ready` in `NUM_REQ`: per-requester response ready.
  - `resp_last` out `NUM_REQ`: final beat of the entire fetch.
  - `resp_data` out `DATA_WIDTH`: shared response data.
- Read-master side:
  - `fetch_req_valid` out 1; `fetch_req_ready` in 1.
  - `fetch_start_address` out `AW`; `fetch_byte_count` out `BCW`.
  - `fetch_resp_valid` in 1; `fetch_resp_ready` out 1; `fetch_resp_data` in `DATA_WIDTH`.
- Status:
  - `grant_id` out `$clog2(NUM_REQ)`: current or last grant index.
  - `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN. Registers: `state`, `grant_id`, `rr_ptr`, `beats_left` (`BCW-5` bits).
- Requester rule: once `req_valid[i]` is asserted, `req_start_address[i]` and `req_byte_count[i]` stay stable until `req_ready[i]`.
- IDLE:
  - If any `req_valid`, select the first asserted index searching upward from `rr_ptr` with wrap, and register it into `grant_id`.
  - If the selected `req_byte_count` is 0: pulse `req_ready[sel]` this cycle, set `rr_ptr = sel+1` (mod `NUM_REQ`), stay IDLE. Nothing is forwarded.
  - Otherwise go to ISSUE.
- ISSUE:
  - `fetch_req_valid = req_valid[grant_id]`; address and byte count pass combinationally from slice `grant_id`.
  - `req_ready[grant_id] = fetch_req_ready`.
  - On handshake: load `beats_left = bc[BCW-1:6] + (bc[5:0] != 0)`, go to DRAIN.
  - If `req_valid[grant_id]` drops before the handshake: return to IDLE, `rr_ptr` unchanged.
- DRAIN:
  - `resp_valid[grant_id] = fetch_resp_valid`; `fetch_resp_ready = resp_ready[grant_id]`; `resp_data = fetch_resp_data`.
  - `resp_last[grant_id] = fetch_resp_valid && beats_left == 1`.
  - Each accepted beat decrements `beats_left`.
  - When the beat with `beats_left == 1` is accepted: go to IDLE, set `rr_ptr = grant_id+1` (mod `NUM_REQ`).
- Outside DRAIN: `fetch_resp_ready = 0`, all `resp_valid` and `resp_last` = 0. Stray read-master beats are held off, not dropped.
- Non-granted requesters always see `req_ready = 0` and `resp_valid = 0`.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `beats_left` 0, `busy` 0. All valid/ready outputs 0; address, count and data outputs 0 or pass-through with valid low.
- Reset mid-fetch returns to IDLE at once and drops `fetch_req_valid`/`fetch_resp_ready`. The read master shares `rst` and clears with it.
- Request latency: `req_valid` seen in IDLE at cycle N → `fetch_req_valid` high at N+1. Earliest `req_ready` is N+1.
- Response path: zero latency, combinational valid/ready/data pass-through. No buffering.
- Grant turnaround: last beat accepted at cycle M → IDLE at M+1 → next `fetch_req_valid` at M+2.
- Simultaneous requests: the round-robin order decides. A request arriving during ISSUE or DRAIN waits, with its `req_ready` low.
- The per-burst `fetch_resp_last` from the read master is ignored. Only `beats_left` ends a grant.
- `resp_ready` low stalls the read master, which back-pressures AXI.

## Test plan
- Single request, `req_valid[2]`, addr `0x1000`, 200 bytes: `fetch_req_valid` one cycle later with `fetch_byte_count = 200` → 4 beats routed to requester 2, `resp_last[2]` on beat 4, `busy` low the next cycle, `rr_ptr = 3`.
- All 4 requesters asserting at reset exit: grants issue in order 0,1,2,3 with no requester granted twice. Each fetch of 64 bytes gives 1 beat with `resp_last`.
- Fetch of 8192 bytes (two 64-beat bursts): `resp_last` only on beat 128. The grant is held across the burst boundary.
- `resp_ready` toggled randomly during a 10-beat fetch: no beat lost or duplicated, data order preserved, `fetch_resp_ready` mirrors `resp_ready[grant_id]`.
- Zero-byte request from requester 1 plus a 64-byte request from requester 2: requester 1 gets a `req_ready` pulse and nothing is forwarded. Requester 2 is then served.
- `rst` asserted mid-DRAIN after 3 of 10 beats: all outputs return to reset values asynchronously. After release, a new request is served normally.
